ieee1500_wsp_ctrl: RTL and testbench
====================================

IEEE1500_WSP_CTRL -- requirements
Module: ieee1500_wsp_ctrl

Interface
REQ-001 SHALL have parameter WIR_WIDTH, default 3, instruction register width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, BIST wait limit in clk cycles.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wsi  in  1  serial data in.
- wso  out  1  serial data out.
- select_wir  in  1  1 = WIR chain, 0 = data register selected by WIR.
- capture_wr  in  1  capture strobe.
- shift_wr  in  1  shift strobe.
- update_wr  in  1  update strobe.
- wcr_cap  in  8  WCR status to capture.
- wdr_cap  in  32  WDR data to capture.
- wbr_cap  in  64  WBR boundary to capture.
- wcr_upd  out  8  WCR value written by ATE.
- wdr_upd  out  32  WDR value written by ATE.
- mbist_enable  out  1  MBIST mux select.
- start_bist  out  1  one-cycle MBIST trigger.
- bist_done  in  1  MBIST done.
- bist_pass  in  1  MBIST pass.
- busy  out  1  RUNBIST in progress.
- timeout  out  1  BIST wait timed out.

Function
REQ-004 Instructions SHALL be: BYPASS=000, WCR=001, WDR=010, WBR=011, RUNBIST=100; codes 101-111 SHALL behave as BYPASS.
REQ-005 Chains SHALL be: WIR shift 3b, bypass 1b, WCR 8b, WDR 32b, WBR 64b, RESULT 2b {done_flag, pass_flag}; RUNBIST SHALL select RESULT.
REQ-006 Strobe priority SHALL be capture > shift > update; lower-priority strobes in the same cycle SHALL be ignored.
REQ-007 Capture SHALL load the selected chain on that edge: WIR chain <- active WIR, bypass <- 0, WCR/WDR/WBR <- *_cap, RESULT <- flags.
REQ-008 Shift SHALL move the selected chain right: sr <= {wsi, sr[N-1:1]}, LSB first.
REQ-009 wso SHALL equal bit 0 of the selected chain, driven from registers only.
REQ-010 Update SHALL copy the chain into the active WIR (select_wir=1), wcr_upd (WCR) or wdr_upd (WDR); outputs SHALL change at the edge sampling update_wr.
- Update on WBR, BYPASS or RESULT SHALL have no effect.
REQ-011 FSM states SHALL be IDLE, START, WAIT, DONE:
- IDLE->START on a WIR update loading RUNBIST.
- START->WAIT after one cycle.
- WAIT->DONE on bist_done=1.
- DONE->IDLE on a WIR update loading a non-RUNBIST code.
REQ-012 start_bist SHALL be 1 only in START, exactly one cycle.
REQ-013 mbist_enable SHALL equal wcr_upd[0] OR (state in START/WAIT/DONE).
REQ-014 busy SHALL be 1 in START and WAIT.
REQ-015 On WAIT->DONE, done_flag SHALL be set to 1 and pass_flag SHALL be set to bist_pass; both flags SHALL clear on IDLE->START.
REQ-016 A WIR update to a non-RUNBIST code in START or WAIT SHALL abort to IDLE without setting flags.
REQ-017 A WIR update reloading RUNBIST in DONE SHALL go directly to START.

Reset
REQ-018 While rst=1 the block SHALL set:
- active WIR = BYPASS and FSM = IDLE.
- all chains, flags and the timeout counter = 0.
- wso, wcr_upd, wdr_upd, mbist_enable, start_bist, busy and timeout = 0.
REQ-019 Reset SHALL override any strobe and any FSM state, including mid-shift and WAIT.

Configuration
REQ-020 Macro WSP_TIMEOUT_EN defined: a counter SHALL run in WAIT.
- After TIMEOUT_CYCLES cycles in WAIT without bist_done, the FSM SHALL go to DONE with done_flag=1, pass_flag=0 and timeout=1.
- timeout SHALL clear on IDLE->START or reset.
REQ-021 Macro WSP_TIMEOUT_EN undefined: WAIT SHALL persist until bist_done or abort; the timeout port SHALL exist and be tied to 0.

Verification
REQ-022 Reset, then capture in BYPASS, shift wsi=1 twice -> wso=0, then 1.
REQ-023 Load WIR=010, capture with wdr_cap=32'hDEADBEEF, shift 32 -> wso bits LSB first (1,1,1,1,0,1,1,1,...); shift in 32'h12345678, update -> wdr_upd=32'h12345678.
REQ-024 Load WIR=001, shift 8'h01, update -> wcr_upd=8'h01, mbist_enable=1.
REQ-025 Load WIR=100 -> start_bist=1 for one cycle, busy=1; bist_done=1 with bist_pass=1 after 100 cycles -> busy=0; RESULT capture shifts out 2'b11.
REQ-026 WSP_TIMEOUT_EN with TIMEOUT_CYCLES=16, bist_done held 0 -> timeout=1 after 16 WAIT cycles; RESULT = 2'b10.
REQ-027 During WAIT load WIR=000 -> FSM IDLE, busy=0, mbist_enable=0 (wcr_upd[0]=0), flags unchanged.

Source files
------------

// File: rtl/ieee1500_wsp_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ieee1500_wsp_ctrl: IEEE 1500 WSP controller with RUNBIST sequencer; WSP_TIMEOUT_EN adds a WAIT timeout. Rev 1.0
// ---------------------------------------------------------------------------
module ieee1500_wsp_ctrl #(
   parameter int unsigned WIR_WIDTH      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wsi,
   output logic        wso,
   input  logic        select_wir,
   input  logic        capture_wr,
   input  logic        shift_wr,
   input  logic        update_wr,
   input  logic [7:0]  wcr_cap,
   input  logic [31:0] wdr_cap,
   input  logic [63:0] wbr_cap,
   output logic [7:0]  wcr_upd,
   output logic [31:0] wdr_upd,
   output logic        mbist_enable,
   output logic        start_bist,
   input  logic        bist_done,
   input  logic        bist_pass,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [2:0] {CH_BYP, CH_WCR, CH_WDR, CH_WBR, CH_RES} chain_t;
   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   localparam logic [WIR_WIDTH-1:0] C_BYPASS  = '0;
   localparam logic [WIR_WIDTH-1:0] C_WCR     = WIR_WIDTH'(1);
   localparam logic [WIR_WIDTH-1:0] C_WDR     = WIR_WIDTH'(2);
   localparam logic [WIR_WIDTH-1:0] C_WBR     = WIR_WIDTH'(3);
   localparam logic [WIR_WIDTH-1:0] C_RUNBIST = WIR_WIDTH'(4);

   if (WIR_WIDTH < 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ieee1500_wsp_ctrl: WIR_WIDTH must be >= 3 and TIMEOUT_CYCLES >= 2");
   end

   logic [WIR_WIDTH-1:0] wir;
   logic [WIR_WIDTH-1:0] wir_sr;
   logic                 byp_sr;
   logic [7:0]           wcr_sr;
   logic [31:0]          wdr_sr;
   logic [63:0]          wbr_sr;
   logic [1:0]           res_sr;
   state_t               state;
   chain_t               chain;
   logic                 done_flag;
   logic                 pass_flag;
   logic                 bist_act;
   logic                 wir_load;
   logic                 load_run;
   logic                 go_start;
   logic                 abort;
   logic                 to_hit;

   always_comb begin
      case (wir)
         C_WCR:     chain = CH_WCR;
         C_WDR:     chain = CH_WDR;
         C_WBR:     chain = CH_WBR;
         C_RUNBIST: chain = CH_RES;
         default:   chain = CH_BYP;
      endcase
   end

   always_comb begin
      wso = byp_sr;
      if (select_wir) begin
         wso = wir_sr[0];
      end else begin
         case (chain)
            CH_WCR:  wso = wcr_sr[0];
            CH_WDR:  wso = wdr_sr[0];
            CH_WBR:  wso = wbr_sr[0];
            CH_RES:  wso = res_sr[0];
            default: wso = byp_sr;
         endcase
      end
   end

   // Only an update that wins the strobe priority can touch the active WIR.
   assign wir_load = update_wr & ~capture_wr & ~shift_wr & select_wir;
   assign load_run = (wir_sr == C_RUNBIST);
   assign go_start = wir_load & load_run & ((state == IDLE) | (state == DONE));
   assign abort    = wir_load & ~load_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         wir     <= C_BYPASS;
         wir_sr  <= '0;
         byp_sr  <= 1'b0;
         wcr_sr  <= '0;
         wdr_sr  <= '0;
         wbr_sr  <= '0;
         res_sr  <= '0;
         wcr_upd <= '0;
         wdr_upd <= '0;
      end else if (capture_wr) begin
         if (select_wir) begin
            wir_sr <= wir;
         end else begin
            case (chain)
               CH_WCR:  wcr_sr <= wcr_cap;
               CH_WDR:  wdr_sr <= wdr_cap;
               CH_WBR:  wbr_sr <= wbr_cap;
               CH_RES:  res_sr <= {done_flag, pass_flag};
               default: byp_sr <= 1'b0;
            endcase
         end
      end else if (shift_wr) begin
         if (select_wir) begin
            wir_sr <= {wsi, wir_sr[WIR_WIDTH-1:1]};
         end else begin
            case (chain)
               CH_WCR:  wcr_sr <= {wsi, wcr_sr[7:1]};
               CH_WDR:  wdr_sr <= {wsi, wdr_sr[31:1]};
               CH_WBR:  wbr_sr <= {wsi, wbr_sr[63:1]};
               CH_RES:  res_sr <= {wsi, res_sr[1]};
               default: byp_sr <= wsi;
            endcase
         end
      end else if (update_wr) begin
         if (select_wir) begin
            wir <= wir_sr;
         end else if (chain == CH_WCR) begin
            wcr_upd <= wcr_sr;
         end else if (chain == CH_WDR) begin
            wdr_upd <= wdr_sr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         start_bist <= 1'b0;
         busy       <= 1'b0;
         bist_act   <= 1'b0;
         done_flag  <= 1'b0;
         pass_flag  <= 1'b0;
      end else begin
         start_bist <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (go_start) begin
                  state      <= START;
                  start_bist <= 1'b1;
                  busy       <= 1'b1;
                  bist_act   <= 1'b1;
                  done_flag  <= 1'b0;
                  pass_flag  <= 1'b0;
               end else if (state == DONE && abort) begin
                  state    <= IDLE;
                  bist_act <= 1'b0;
               end
            end
            START: begin
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  bist_act <= 1'b0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  bist_act <= 1'b0;
               end else if (bist_done || to_hit) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done_flag <= 1'b1;
                  pass_flag <= bist_done & bist_pass;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mbist_enable = wcr_upd[0] | bist_act;

`ifdef WSP_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] wait_cnt;

   assign to_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : '0;
         if (go_start) begin
            timeout <= 1'b0;
         end else if (state == WAIT && !abort && !bist_done && to_hit) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ieee1500_wsp_ctrl.sv
`default_nettype none
// tb_ieee1500_wsp_ctrl: directed bench for the WSP controller; table of single-strobe vectors plus multi-cycle sequences.
module tb_ieee1500_wsp_ctrl;
   localparam int TO = 16;
`ifdef WSP_TIMEOUT_EN
   localparam int WAIT_N = 10;
`else
   localparam int WAIT_N = 100;
`endif

   logic        clk = 1'b0;
   logic        rst, wsi, wso, select_wir, capture_wr, shift_wr, update_wr;
   logic [7:0]  wcr_cap, wcr_upd;
   logic [31:0] wdr_cap, wdr_upd;
   logic [63:0] wbr_cap;
   logic        mbist_enable, start_bist, bist_done, bist_pass, busy, timeout;
   logic [63:0] d;

   int npass  = 0;
   int ntotal = 0;

   typedef struct {
      logic sw, cap, sh, up, din, exp_wso;
   } vec_t;
   vec_t tbl [12];

   ieee1500_wsp_ctrl #(.WIR_WIDTH(3), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .wsi(wsi), .wso(wso), .select_wir(select_wir),
      .capture_wr(capture_wr), .shift_wr(shift_wr), .update_wr(update_wr),
      .wcr_cap(wcr_cap), .wdr_cap(wdr_cap), .wbr_cap(wbr_cap),
      .wcr_upd(wcr_upd), .wdr_upd(wdr_upd), .mbist_enable(mbist_enable),
      .start_bist(start_bist), .bist_done(bist_done), .bist_pass(bist_pass),
      .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      ntotal++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic sw, input logic c, input logic s, input logic u, input logic din);
      select_wir = sw; capture_wr = c; shift_wr = s; update_wr = u; wsi = din;
      tick();
      capture_wr = 1'b0; shift_wr = 1'b0; update_wr = 1'b0; wsi = 1'b0;
   endtask

   task automatic load_wir(input logic [2:0] code);
      strobe(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) strobe(1, 0, 1, 0, code[i]);
      strobe(1, 0, 0, 1, 0);
      select_wir = 1'b0;
   endtask

   task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
      dout = '0;
      for (int i = 0; i < n; i++) begin
         dout[i] = wso;
         strobe(0, 0, 1, 0, din[i]);
      end
   endtask

   task automatic write_wcr(input logic [7:0] v);
      load_wir(3'b001);
      strobe(0, 1, 0, 0, 0);
      shift_dr(8, {56'd0, v}, d);
      strobe(0, 0, 0, 1, 0);
   endtask

   initial begin
      rst = 1'b1; wsi = 0; select_wir = 0; capture_wr = 0; shift_wr = 0; update_wr = 0;
      wcr_cap = 8'h00; wdr_cap = 32'h0; wbr_cap = 64'h0; bist_done = 0; bist_pass = 0;
      // Rows: {select_wir, capture, shift, update, wsi, expected wso after the edge}
      tbl[0]  = '{0, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 0, 1, 1};
      tbl[2]  = '{0, 0, 1, 0, 1, 1};
      tbl[3]  = '{0, 1, 1, 0, 1, 0};
      tbl[4]  = '{0, 0, 1, 0, 1, 1};
      tbl[5]  = '{0, 0, 1, 1, 1, 1};
      tbl[6]  = '{1, 0, 0, 0, 0, 0};
      tbl[7]  = '{1, 0, 1, 0, 1, 0};
      tbl[8]  = '{1, 0, 1, 0, 1, 0};
      tbl[9]  = '{1, 0, 1, 0, 0, 1};
      tbl[10] = '{1, 1, 0, 1, 0, 0};
      tbl[11] = '{0, 0, 0, 0, 0, 1};

      repeat (3) tick();
      check("reset_ctl", {59'd0, wso, mbist_enable, start_bist, busy, timeout}, 64'd0);
      check("reset_wcr", wcr_upd, 64'd0);
      check("reset_wdr", wdr_upd, 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         strobe(tbl[i].sw, tbl[i].cap, tbl[i].sh, tbl[i].up, tbl[i].din);
         check($sformatf("vec%0d_wso", i), wso, tbl[i].exp_wso);
      end

      load_wir(3'b010);
      wdr_cap = 32'hDEADBEEF;
      strobe(0, 1, 0, 0, 0);
      shift_dr(32, 64'h12345678, d);
      check("wdr_shift_out", d, 64'hDEADBEEF);
      check("wdr_before_upd", wdr_upd, 64'd0);
      strobe(0, 0, 0, 1, 0);
      check("wdr_upd", wdr_upd, 64'h12345678);

      load_wir(3'b011);
      wbr_cap = 64'h0123456789ABCDEF;
      strobe(0, 1, 0, 0, 0);
      shift_dr(64, 64'hFFFF0000FFFF0000, d);
      check("wbr_shift_out", d, 64'h0123456789ABCDEF);
      strobe(0, 0, 0, 1, 0);
      check("wbr_upd_no_wdr", wdr_upd, 64'h12345678);
      check("wbr_upd_no_wcr", wcr_upd, 64'd0);

      load_wir(3'b001);
      wcr_cap = 8'hA5;
      strobe(0, 1, 0, 0, 0);
      shift_dr(8, 64'h01, d);
      check("wcr_shift_out", d, 64'hA5);
      strobe(0, 0, 0, 1, 0);
      check("wcr_upd", wcr_upd, 64'h01);
      check("wcr_mbist_en", mbist_enable, 1);

      load_wir(3'b101);
      strobe(0, 1, 0, 0, 0);
      shift_dr(2, 64'h3, d);
      check("alias_bypass_out", d, 64'h2);
      strobe(0, 0, 0, 1, 0);
      check("alias_upd_no_wcr", wcr_upd, 64'h01);

      write_wcr(8'h00);
      check("wcr_clear_mbist", mbist_enable, 0);

      // RUNBIST with a passing MBIST
      load_wir(3'b100);
      check("run_start", {start_bist, busy, mbist_enable}, 64'h7);
      tick();
      check("run_wait", {start_bist, busy}, 64'h1);
      repeat (WAIT_N) tick();
      check("run_still_busy", {busy, timeout}, 64'h2);
      bist_done = 1'b1; bist_pass = 1'b1;
      tick();
      bist_done = 1'b0; bist_pass = 1'b0;
      check("run_done", {start_bist, busy, mbist_enable, timeout}, 64'h2);
      strobe(0, 1, 0, 0, 0);
      shift_dr(2, 64'h0, d);
      check("run_result", d, 64'h3);

      // DONE straight back to START; flags cleared
      load_wir(3'b100);
      check("rerun_start", {start_bist, busy}, 64'h3);
      strobe(0, 1, 0, 0, 0);
      shift_dr(2, 64'h0, d);
      check("rerun_flags_clr", d, 64'h0);
      check("rerun_busy", busy, 1);

      // Abort from WAIT
      load_wir(3'b000);
      check("abort_idle", {start_bist, busy, mbist_enable}, 64'h0);
      repeat (5) tick();
      check("abort_stays_idle", {start_bist, busy, timeout}, 64'h0);

`ifdef WSP_TIMEOUT_EN
      load_wir(3'b100);
      tick();
      repeat (TO - 1) tick();
      check("to_last_wait", {busy, timeout}, 64'h2);
      tick();
      check("to_fired", {busy, timeout, mbist_enable}, 64'h3);
      strobe(0, 1, 0, 0, 0);
      shift_dr(2, 64'h0, d);
      check("to_result", d, 64'h2);
      load_wir(3'b100);
      check("to_clr_on_start", {start_bist, timeout}, 64'h2);
      load_wir(3'b000);
`else
      load_wir(3'b100);
      repeat (40) tick();
      check("no_to_busy", {busy, timeout}, 64'h2);
      load_wir(3'b000);
`endif

      // Reset in WAIT with a shift in flight
      write_wcr(8'h01);
      load_wir(3'b100);
      tick();
      rst = 1'b1; shift_wr = 1'b1; wsi = 1'b1;
      tick();
      check("midrst_ctl", {59'd0, wso, mbist_enable, start_bist, busy, timeout}, 64'd0);
      check("midrst_wcr", wcr_upd, 64'd0);
      check("midrst_wdr", wdr_upd, 64'd0);
      rst = 1'b0; shift_wr = 1'b0; wsi = 1'b0;
      tick();
      strobe(0, 1, 0, 0, 0);
      shift_dr(2, 64'h3, d);
      check("midrst_bypass", d, 64'h2);
      check("midrst_idle", {start_bist, busy}, 64'h0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
`default_nettype wire
